// File: rtl/fifo_pkg.sv
// Shared types and pointer-code helpers for the async FIFO write side.
package fifo_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned CODE_W         = 32;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended Gray codes decode correctly because the leading zeros contribute nothing.
    function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
        logic [CODE_W-1:0] b;
        b[CODE_W-1] = g[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter.sv
// Combinational round-robin pick: first asserted request after rr_last, wrapping modulo NUM_REQ.
module fifo_rr_arbiter
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
)
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               valid
);

    int unsigned      idx;
    logic [IDX_W-1:0] idx_w;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            idx   = (32'(rr_last) + 32'(k)) % NUM_REQ;
            idx_w = IDX_W'(idx);
            if (!valid && req[idx_w]) begin
                valid      = 1'b1;
                gnt[idx_w] = 1'b1;
                gnt_idx    = idx_w;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_port_arbiter.sv
// Async FIFO write side: packet-aware round-robin write-port sharing plus pointer/flag logic.
// Optional stall statistics are built when FIFO_WR_ARB_STALL_STATS_EN is defined.
module fifo_wr_port_arbiter
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned AFULL_THRESH = 2
)
(
    input  logic                          wr_clk,
    input  logic                          wr_rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic [ADDR_WIDTH:0]           rdptr_sync,
    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [ADDR_WIDTH:0]           wr_ptr_gray,
    output logic                          full,
    output logic                          almost_full,
    output logic [ADDR_WIDTH:0]           fill_level,
    output logic [15:0]                   stall_cnt
);

    localparam int unsigned PTR_W       = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH       = 2 ** ADDR_WIDTH;
    localparam int unsigned IDX_W       = $clog2(NUM_REQ);
    localparam int unsigned AFULL_LEVEL = DEPTH - AFULL_THRESH;

    arb_state_t       state, state_n;
    logic [IDX_W-1:0] rr_last, rr_last_n;
    logic [IDX_W-1:0] owner, owner_n;
    logic [IDX_W-1:0] sel;

    logic [NUM_REQ-1:0] arb_req, arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;

    logic [PTR_W-1:0] wbin, wbin_n, wgray_n, rbin, fill_n;
    logic             full_n, afull_n;

    // New packets compete only in ARB and never while full.
    assign arb_req = (state == ST_ARB && !full) ? req : '0;

    fifo_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req     (arb_req),
        .rr_last (rr_last),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .valid   (arb_valid)
    );

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state   <= ST_ARB;
            rr_last <= IDX_W'(NUM_REQ - 1);
            owner   <= '0;
        end else begin
            state   <= state_n;
            rr_last <= rr_last_n;
            owner   <= owner_n;
        end
    end

    always_comb begin
        state_n   = state;
        rr_last_n = rr_last;
        owner_n   = owner;
        gnt       = '0;
        sel       = owner;
        case (state)
            ST_ARB: begin
                if (arb_valid) begin
                    gnt       = arb_gnt;
                    sel       = arb_idx;
                    rr_last_n = arb_idx;
                    if (!req_last[arb_idx]) begin
                        owner_n = arb_idx;
                        state_n = ST_LOCK;
                    end
                end
            end
            ST_LOCK: begin
                // Owner keeps the port until its last word, even if it idles.
                if (req[owner] && !full) begin
                    gnt[owner] = 1'b1;
                    if (req_last[owner]) begin
                        state_n = ST_ARB;
                    end
                end
            end
            default: state_n = ST_ARB;
        endcase
    end

    assign wr_en   = |gnt;
    assign wr_addr = wbin[ADDR_WIDTH-1:0];
    assign wr_data = wr_en ? req_data[32'(sel)*DATA_WIDTH +: DATA_WIDTH] : '0;

    // Flags look at the post-write pointer so a write is reflected on the same edge.
    always_comb begin
        wbin_n  = wbin + PTR_W'(wr_en);
        wgray_n = PTR_W'(bin2gray(CODE_W'(wbin_n)));
        rbin    = PTR_W'(gray2bin(CODE_W'(rdptr_sync)));
        fill_n  = wbin_n - rbin;
        full_n  = (wgray_n == {~rdptr_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                               rdptr_sync[ADDR_WIDTH-2:0]});
        afull_n = (fill_n >= PTR_W'(AFULL_LEVEL));
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wbin        <= '0;
            wr_ptr_gray <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            fill_level  <= '0;
        end else begin
            wbin        <= wbin_n;
            wr_ptr_gray <= wgray_n;
            full        <= full_n;
            almost_full <= afull_n;
            fill_level  <= fill_n;
        end
    end

`ifdef FIFO_WR_ARB_STALL_STATS_EN
    // Saturating count of cycles where someone wants to write into a full FIFO.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            stall_cnt <= '0;
        end else if ((|req) && full && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_port_arbiter.sv
// Directed self-checking bench for fifo_wr_port_arbiter with hand-computed expectations.
module tb_fifo_wr_port_arbiter;

    logic        wr_clk = 1'b0;
    logic        wr_rst;
    logic [3:0]  req, req_last, gnt;
    logic [31:0] req_data;
    logic [4:0]  rdptr_sync, wr_ptr_gray, fill_level;
    logic        wr_en, full, almost_full;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 wr_clk = ~wr_clk;

    fifo_wr_port_arbiter dut (
        .wr_clk      (wr_clk),
        .wr_rst      (wr_rst),
        .req         (req),
        .req_last    (req_last),
        .req_data    (req_data),
        .gnt         (gnt),
        .rdptr_sync  (rdptr_sync),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ptr_gray (wr_ptr_gray),
        .full        (full),
        .almost_full (almost_full),
        .fill_level  (fill_level),
        .stall_cnt   (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change 1 time unit after it, outputs are sampled 2 after.
    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        wr_rst     = 1'b1;
        req        = '0;
        req_last   = '0;
        rdptr_sync = '0;
        tick();
        wr_rst = 1'b0;
        #1;
    endtask

    logic [3:0] exp_gnt [5];
    logic [15:0] exp_stall;

    initial begin
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
        exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;

        do_reset();
        check("rst_full",  32'(full), 0);
        check("rst_afull", 32'(almost_full), 0);
        check("rst_fill",  32'(fill_level), 0);
        check("rst_gray",  32'(wr_ptr_gray), 0);
        check("rst_stall", 32'(stall_cnt), 0);
        check("rst_gnt",   32'(gnt), 0);
        check("rst_wdata", 32'(wr_data), 0);

        // Single-word packets from all requesters rotate round-robin.
        req = 4'b1111; req_last = 4'b1111;
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_gnt%0d", i),   32'(gnt), 32'(exp_gnt[i]));
            check($sformatf("rr_addr%0d", i),  32'(wr_addr), i);
            check($sformatf("rr_data%0d", i),  32'(wr_data), 32'h0A0 + 32'(i % 4));
            tick();
        end
        req = '0;
        #1;
        check("rr_fill", 32'(fill_level), 5);

        // Three-word packet from req0 holds the port against req1.
        do_reset();
        req = 4'b0011; req_last = 4'b0000;
        #1;
        check("pkt_w1", 32'(gnt), 4'b0001);
        tick();
        check("pkt_w2", 32'(gnt), 4'b0001);
        tick();
        req_last = 4'b0011;
        #1;
        check("pkt_w3", 32'(gnt), 4'b0001);
        tick();
        check("pkt_next", 32'(gnt), 4'b0010);
        check("pkt_next_data", 32'(wr_data), 8'hA1);
        tick();
        req = '0;
        #1;
        check("pkt_fill", 32'(fill_level), 4);

        // Fill to full with rdptr_sync at 0.
        do_reset();
        req = 4'b0001; req_last = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 13) check("fill13_afull", 32'(almost_full), 0);
            if (k == 14) check("fill14_afull", 32'(almost_full), 1);
            if (k == 15) check("fill15_full",  32'(full), 0);
        end
        check("full_flag",  32'(full), 1);
        check("full_gray",  32'(wr_ptr_gray), 5'b11000);
        check("full_fill",  32'(fill_level), 16);
        check("full_gnt",   32'(gnt), 0);
        check("full_wr_en", 32'(wr_en), 0);
        tick();
        check("full_hold_gray", 32'(wr_ptr_gray), 5'b11000);

        // One read observed: room for one more word, written at the wrapped address.
        rdptr_sync = 5'b00001;
        tick();
        check("rd1_full",  32'(full), 0);
        check("rd1_fill",  32'(fill_level), 15);
        check("rd1_afull", 32'(almost_full), 1);
        check("rd1_gnt",   32'(gnt), 4'b0001);
        check("rd1_addr",  32'(wr_addr), 0);
        tick();
        check("rd1_refull", 32'(full), 1);
        check("rd1_gray",   32'(wr_ptr_gray), 5'b11001);

        // Reset while locked to requester 2.
        do_reset();
        req = 4'b0100; req_last = 4'b0000;
        #1;
        check("lock_gnt2", 32'(gnt), 4'b0100);
        tick();
        req = 4'b0101;
        #1;
        check("lock_only_owner", 32'(gnt), 4'b0100);
        wr_rst = 1'b1;
        tick();
        wr_rst = 1'b0;
        #1;
        check("lrst_fill", 32'(fill_level), 0);
        check("lrst_gray", 32'(wr_ptr_gray), 0);
        check("lrst_full", 32'(full), 0);
        check("lrst_gnt",  32'(gnt), 4'b0001);
        check("lrst_addr", 32'(wr_addr), 0);

        // Stall statistics: 5 cycles of request while full.
        do_reset();
        req = 4'b0001; req_last = 4'b0001;
        for (int k = 0; k < 16; k++) tick();
        check("stall_pre", 32'(stall_cnt), 0);
        for (int k = 0; k < 5; k++) tick();
        req = '0;
        tick();
`ifdef FIFO_WR_ARB_STALL_STATS_EN
        exp_stall = 16'd5;
`else
        exp_stall = 16'd0;
`endif
        check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_port_arbiter.md
Name: fifo_wr_port_arbiter

Overview:
Write-side controller for the async FIFO. It shares the single FIFO write port between NUM_REQ requesters using packet-aware round-robin arbitration. It owns the write pointer (binary and Gray) and derives full, almost_full and fill level from the read pointer already synchronised into wr_clk. It sits in the write clock domain between the requesters and the dual-port FIFO memory, and feeds wr_ptr_gray to the read-side synchroniser.

Parameters:
ADDR_WIDTH, 4, FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
DATA_WIDTH, 8, write data width
NUM_REQ, 4, number of requesters (2..8)
AFULL_THRESH, 2, almost_full asserts when free entries <= AFULL_THRESH

Ports:
wr_clk  in  1  write-domain clock
wr_rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester write request
req_last  in  NUM_REQ  marks the final word of a requester's packet
req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH]
gnt  out  NUM_REQ  one-hot accept; a word transfers when req[i] & gnt[i]
rdptr_sync  in  ADDR_WIDTH+1  read pointer, Gray-coded, already synchronised to wr_clk
wr_en  out  1  memory write strobe
wr_addr  out  ADDR_WIDTH  memory write address
wr_data  out  DATA_WIDTH  memory write data
wr_ptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, to the read-side synchroniser
full  out  1  registered full flag
almost_full  out  1  registered almost-full flag
fill_level  out  ADDR_WIDTH+1  registered occupancy estimate (0..DEPTH)
stall_cnt  out  16  stall statistics (see Optional Feature)

Behaviour:
- Reset (wr_rst=1 at posedge wr_clk): wbin, wr_ptr_gray, full, almost_full, fill_level, stall_cnt = 0; FSM=ARB; rr_last=NUM_REQ-1; owner=0.
- Reset mid-packet aborts the lock with no flush; words already written remain counted until the read side also resets.
- gnt, wr_en, wr_addr and wr_data are combinational within the cycle:
  - wr_en = |gnt.
  - wr_addr = wbin[ADDR_WIDTH-1:0].
  - wr_data = the req_data slice of the granted requester, else 0.
- No grant is issued while full=1.
- FSM ARB:
  - Grant the first asserted req searching rr_last+1, rr_last+2, ... modulo NUM_REQ.
  - On a grant to i: rr_last<=i.
  - If req_last[i]=0: owner<=i and go to LOCK.
  - If req_last[i]=1 (single-word packet): stay in ARB.
- FSM LOCK:
  - Only owner can be granted; gnt[owner]=req[owner]&!full.
  - A granted word with req_last[owner]=1 returns to ARB.
  - If owner drops req, the block stays in LOCK indefinitely (no timeout); other requesters are blocked.
- Pointer update:
  - wbin_n = wbin + wr_en (mod 2**(ADDR_WIDTH+1)).
  - wgray_n = wbin_n ^ (wbin_n>>1).
  - Registered: wbin<=wbin_n, wr_ptr_gray<=wgray_n.
- full <= (wgray_n == {~rdptr_sync[AW:AW-1], rdptr_sync[AW-2:0]}), where AW = ADDR_WIDTH. Wrap-around is handled by the extra MSB.
- fill_level:
  - rbin = Gray-to-binary(rdptr_sync).
  - fill_level <= wbin_n - rbin (mod 2**(ADDR_WIDTH+1)).
  - almost_full <= fill_level_next >= DEPTH-AFULL_THRESH.
- Flags are pessimistic because of synchroniser latency: full may stay high up to 2 cycles after a read; this is required and not an error.
- Simultaneous write and rdptr_sync change: both are used in the same next-state computation; there is no priority issue.
- Latency: a granted word is in memory at the next edge; full reflects that write in the same edge.

Optional Feature:
Macro FIFO_WR_ARB_STALL_STATS_EN.
- Defined: stall_cnt increments by 1 each cycle where (|req) & full, saturating at 16'hFFFF; it is cleared only by wr_rst.
- Not defined: stall_cnt is tied to 0 and no counter flops exist.
- All other behaviour is identical in both builds.

Decomposition:
- Package fifo_pkg holds:
  - the ARB/LOCK state enum;
  - a gray2bin function;
  - a bin2gray function;
  - the default ADDR_WIDTH and DATA_WIDTH constants.
- One sub-module, fifo_rr_arbiter: combinational round-robin one-hot pick given req mask and rr_last. The top instantiates it and masks its input with owner/full.

Test Plan:
- Reset, then req=4'b1111 with req_last=4'b1111, rdptr_sync=0 -> gnt sequence 0001,0010,0100,1000,0001; wr_addr 0,1,2,3,4.
- req0 sends a 3-word packet (req_last on word 3) while req1 is held high -> gnt=0001 for 3 consecutive cycles, then 0010.
- Write 16 words with rdptr_sync held at 0 -> full=1 after the 16th edge; wr_ptr_gray=5'b11000; gnt=0 while full; almost_full=1 from fill_level 14.
- Then drive rdptr_sync=Gray(1)=5'b00001 -> full=0 next edge, fill_level=15, writing resumes at wr_addr 0 (wrap).
- Assert wr_rst for 1 cycle while in LOCK with owner=2 -> all outputs 0, FSM=ARB, next grant goes to the lowest asserted req starting at index 0.
- With FIFO_WR_ARB_STALL_STATS_EN: hold full with req=0001 for 5 cycles -> stall_cnt=5.
- Without FIFO_WR_ARB_STALL_STATS_EN: same stimulus -> stall_cnt=0.
